byte_demux_packer: RTL and testbench

BYTE_DEMUX_PACKER -- requirements
Module: byte_demux_packer

---
 rtl/byte_demux_packer_if.sv | 32 +++
 rtl/byte_demux_packer.sv | 116 +++++++++++
 tb/tb_byte_demux_packer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/byte_demux_packer_if.sv
// ============================================================================
// byte_demux_packer_if : byte-in / word-out handshake bundle for byte_demux_packer
// Revision: 1.0
// ============================================================================
`default_nettype none

interface byte_demux_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic        sel;
  logic [7:0]  in_data;
  logic [7:0]  out_a;
  logic [7:0]  out_b;
  logic [15:0] out_word;
  logic        out_valid;
  logic        out_ready;
  logic        a_full;
  logic        b_full;
  logic        err_dup;

  modport slave (
    input  in_valid, sel, in_data, out_ready,
    output in_ready, out_a, out_b, out_word, out_valid, a_full, b_full, err_dup
  );

  modport master (
    output in_valid, sel, in_data, out_ready,
    input  in_ready, out_a, out_b, out_word, out_valid, a_full, b_full, err_dup
  );
endinterface

`default_nettype wire

// File: rtl/byte_demux_packer.sv
// ============================================================================
// byte_demux_packer : routes bytes into lane A (high) / lane B (low) and
//                     presents the completed 16-bit word with valid/ready.
// Revision: 1.0
// ============================================================================
`default_nettype none

module byte_demux_packer #(
  parameter bit ALLOW_OVERWRITE = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  byte_demux_packer_if.slave bus
);

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_HAVE_A = 2'd1,
    S_HAVE_B = 2'd2,
    S_FULL   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic       err_q, err_d;

  logic       w_in_ready;
  logic       w_accept;

  // No bypass: a FULL word must be popped before the next byte is taken.
  assign w_in_ready = rst_n && (state_q != S_FULL) && !clear;
  assign w_accept   = bus.in_valid && w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q;

    if (clear) begin
      state_d = S_EMPTY;
      a_d     = 8'h00;
      b_d     = 8'h00;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (w_accept) begin
            if (bus.sel) begin
              a_d     = bus.in_data;
              state_d = S_HAVE_A;
            end else begin
              b_d     = bus.in_data;
              state_d = S_HAVE_B;
            end
          end
        end
        S_HAVE_A: begin
          if (w_accept) begin
            if (bus.sel) begin
              if (ALLOW_OVERWRITE) a_d = bus.in_data;
              else                 err_d = 1'b1;
            end else begin
              b_d     = bus.in_data;
              state_d = S_FULL;
            end
          end
        end
        S_HAVE_B: begin
          if (w_accept) begin
            if (!bus.sel) begin
              if (ALLOW_OVERWRITE) b_d = bus.in_data;
              else                 err_d = 1'b1;
            end else begin
              a_d     = bus.in_data;
              state_d = S_FULL;
            end
          end
        end
        S_FULL: begin
          // Lanes keep their contents after the pop; only the state empties.
          if (bus.out_ready) state_d = S_EMPTY;
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_a     = a_q;
  assign bus.out_b     = b_q;
  assign bus.out_word  = {a_q, b_q};
  assign bus.out_valid = (state_q == S_FULL);
  assign bus.a_full    = (state_q == S_HAVE_A) || (state_q == S_FULL);
  assign bus.b_full    = (state_q == S_HAVE_B) || (state_q == S_FULL);
  assign bus.err_dup   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_byte_demux_packer.sv
// ============================================================================
// tb_byte_demux_packer : drives both ALLOW_OVERWRITE variants with identical
//                        stimulus; model + scoreboard check every cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_byte_demux_packer;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       clear     = 1'b0;
  logic       in_valid  = 1'b0;
  logic       sel       = 1'b0;
  logic [7:0] in_data   = 8'h00;
  logic       out_ready = 1'b0;

  always #5 clk = ~clk;

  byte_demux_packer_if if0 ();
  byte_demux_packer_if if1 ();

  assign if0.in_valid  = in_valid;
  assign if0.sel       = sel;
  assign if0.in_data   = in_data;
  assign if0.out_ready = out_ready;
  assign if1.in_valid  = in_valid;
  assign if1.sel       = sel;
  assign if1.in_data   = in_data;
  assign if1.out_ready = out_ready;

  byte_demux_packer #(.ALLOW_OVERWRITE(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(if0.slave)
  );
  byte_demux_packer #(.ALLOW_OVERWRITE(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(if1.slave)
  );

  logic [1:0]  o_ready, o_valid, o_afull, o_bfull, o_err;
  logic [7:0]  o_a [2];
  logic [7:0]  o_b [2];
  logic [15:0] o_w [2];

  assign o_ready[0] = if0.in_ready;  assign o_ready[1] = if1.in_ready;
  assign o_valid[0] = if0.out_valid; assign o_valid[1] = if1.out_valid;
  assign o_afull[0] = if0.a_full;    assign o_afull[1] = if1.a_full;
  assign o_bfull[0] = if0.b_full;    assign o_bfull[1] = if1.b_full;
  assign o_err[0]   = if0.err_dup;   assign o_err[1]   = if1.err_dup;
  assign o_a[0]     = if0.out_a;     assign o_a[1]     = if1.out_a;
  assign o_b[0]     = if0.out_b;     assign o_b[1]     = if1.out_b;
  assign o_w[0]     = if0.out_word;  assign o_w[1]     = if1.out_word;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [dut%0d] t=%0t: got 0x%0h, expected 0x%0h", name, i, $time, act, exp);
    end
  endtask

  // ---------------- reference model: two lane slots with "loaded" flags ----
  logic [7:0]  m_a [2];
  logic [7:0]  m_b [2];
  bit          m_ha [2];
  bit          m_hb [2];
  bit          m_err [2];
  logic [15:0] exp_q0 [$];
  logic [15:0] exp_q1 [$];

  function automatic void q_push(input int i, input logic [15:0] w);
    if (i == 0) exp_q0.push_back(w); else exp_q1.push_back(w);
  endfunction

  function automatic void q_flush(input int i);
    if (i == 0) exp_q0.delete(); else exp_q1.delete();
  endfunction

  function automatic int q_size(input int i);
    return (i == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [15:0] q_pop(input int i);
    return (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit ovw;
      bit was_full;
      ovw = (i == 1);
      if (!rst_n) begin
        m_a[i] = 8'h00; m_b[i] = 8'h00;
        m_ha[i] = 1'b0; m_hb[i] = 1'b0; m_err[i] = 1'b0;
        q_flush(i);
        chk("rst_in_ready", i, o_ready[i], 0);
        chk("rst_out_valid", i, o_valid[i], 0);
        chk("rst_word", i, o_w[i], 0);
        chk("rst_err", i, o_err[i], 0);
      end else begin
        was_full = m_ha[i] && m_hb[i];
        chk("in_ready", i, o_ready[i], !was_full && !clear);
        chk("out_valid", i, o_valid[i], was_full);
        chk("a_full", i, o_afull[i], m_ha[i]);
        chk("b_full", i, o_bfull[i], m_hb[i]);
        chk("err_dup", i, o_err[i], m_err[i]);
        chk("out_word", i, o_w[i], {m_a[i], m_b[i]});
        chk("out_a", i, o_a[i], m_a[i]);
        chk("out_b", i, o_b[i], m_b[i]);

        if (clear) begin
          m_a[i] = 8'h00; m_b[i] = 8'h00;
          m_ha[i] = 1'b0; m_hb[i] = 1'b0; m_err[i] = 1'b0;
          q_flush(i);
        end else if (was_full) begin
          if (out_ready) begin m_ha[i] = 1'b0; m_hb[i] = 1'b0; end
        end else if (in_valid) begin
          if (sel) begin
            if (m_ha[i] && !ovw) m_err[i] = 1'b1;
            else begin m_a[i] = in_data; m_ha[i] = 1'b1; end
          end else begin
            if (m_hb[i] && !ovw) m_err[i] = 1'b1;
            else begin m_b[i] = in_data; m_hb[i] = 1'b1; end
          end
          if (m_ha[i] && m_hb[i]) q_push(i, {m_a[i], m_b[i]});
        end
      end
    end
  end

  // ---------------- monitor: pops on handshake, checks hold stability ------
  bit          hold [2];
  logic [15:0] held_w [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_n && hold[i]) chk("hold_stable", i, o_w[i], held_w[i]);
      if (rst_n && !clear && o_valid[i] && out_ready) begin
        if (q_size(i) == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected [dut%0d] t=%0t: got word 0x%0h, expected none", i, $time, o_w[i]);
        end else begin
          chk("popped_word", i, o_w[i], q_pop(i));
        end
      end
      hold[i]   = rst_n && !clear && o_valid[i] && !out_ready;
      held_w[i] = o_w[i];
    end
  end

  task automatic drive(input bit v, input bit s, input logic [7:0] d, input bit r, input bit c);
    @(posedge clk);
    #1;
    in_valid  = v;
    sel       = s;
    in_data   = d;
    out_ready = r;
    clear     = c;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // basic pack and pop
    drive(1, 1, 8'h12, 1, 0);
    drive(1, 0, 8'h34, 1, 0);
    drive(0, 0, 8'h00, 1, 0);
    sample();
    for (int i = 0; i < 2; i++) begin
      chk("d1_valid", i, o_valid[i], 1);
      chk("d1_word", i, o_w[i], 16'h1234);
    end
    drive(0, 0, 8'h00, 0, 0);
    sample();
    for (int i = 0; i < 2; i++) chk("d1_ready_after_pop", i, o_ready[i], 1);

    // back-pressure with ignored bytes while full
    drive(1, 0, 8'hCD, 0, 0);
    drive(1, 1, 8'hAB, 0, 0);
    for (int k = 0; k < 5; k++) drive(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 0, 0);
    sample();
    for (int i = 0; i < 2; i++) chk("d2_word", i, o_w[i], 16'hABCD);
    drive(0, 0, 8'h00, 1, 0);

    // duplicate lane
    drive(1, 1, 8'h11, 0, 0);
    drive(1, 1, 8'h22, 0, 0);
    drive(0, 0, 8'h00, 0, 0);
    sample();
    chk("d3_a_noovw", 0, o_a[0], 8'h11);
    chk("d3_err_noovw", 0, o_err[0], 1);
    chk("d3_a_ovw", 1, o_a[1], 8'h22);
    chk("d3_err_ovw", 1, o_err[1], 0);
    drive(0, 0, 8'h00, 0, 1);

    // clear collides with an incoming byte
    drive(1, 1, 8'h55, 0, 0);
    drive(1, 0, 8'h66, 0, 1);
    drive(0, 0, 8'h00, 0, 0);
    sample();
    for (int i = 0; i < 2; i++) begin
      chk("d4_word", i, o_w[i], 16'h0000);
      chk("d4_bfull", i, o_bfull[i], 0);
    end

    // asynchronous reset while full
    drive(1, 1, 8'h12, 0, 0);
    drive(1, 0, 8'h34, 0, 0);
    drive(0, 0, 8'h00, 0, 0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("d5_async_valid", i, o_valid[i], 0);
      chk("d5_async_afull", i, o_afull[i], 0);
      chk("d5_async_bfull", i, o_bfull[i], 0);
      chk("d5_async_ready", i, o_ready[i], 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1, 0, 8'h99, 0, 0);
    drive(1, 1, 8'h88, 0, 0);
    drive(0, 0, 8'h00, 0, 0);
    sample();
    for (int i = 0; i < 2; i++) chk("d5_word", i, o_w[i], 16'h8899);
    drive(0, 0, 8'h00, 1, 0);

    // randomized traffic
    repeat (10000) begin
      drive($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), $urandom_range(0, 99) < 2);
    end

    repeat (4) drive(0, 0, 8'h00, 1, 0);
    sample();
    for (int i = 0; i < 2; i++) chk("drained", i, q_size(i), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
